// File: rtl/ctr_pkg.sv
// Shared types and constants for the two-copy retirement-observation checker.
// One observation is a 96-bit record: four instruction bytes plus two operand values.
package ctr_pkg;

  localparam int CTR_XLEN   = 32;
  localparam int CTR_NFIELD = 6;

  localparam int CTR_F_OP   = 0;
  localparam int CTR_F_RD   = 1;
  localparam int CTR_F_RS1  = 2;
  localparam int CTR_F_RS2  = 3;
  localparam int CTR_F_RS1V = 4;
  localparam int CTR_F_RS2V = 5;

  localparam logic [7:0] ALU_NO_OP   = 8'h00;
  localparam logic [7:0] ALU_ADD_REG = 8'h01;
  localparam logic [7:0] ALU_ADD_IMM = 8'h02;
  localparam logic [7:0] ALU_MUL_REG = 8'h03;
  localparam logic [7:0] ALU_MUL_IMM = 8'h04;

  typedef struct packed {
    logic [7:0]          op;
    logic [7:0]          rd;
    logic [7:0]          rs1;
    logic [7:0]          rs2;
    logic [CTR_XLEN-1:0] reg_rs1;
    logic [CTR_XLEN-1:0] reg_rs2;
  } ctr_obs_t;

  // Per-field inequality, gated by the runtime compare mask.
  function automatic logic [CTR_NFIELD-1:0] obs_diff(input ctr_obs_t a,
                                                     input ctr_obs_t b,
                                                     input logic [CTR_NFIELD-1:0] mask);
    logic [CTR_NFIELD-1:0] d;
    d[CTR_F_OP]   = (a.op      != b.op);
    d[CTR_F_RD]   = (a.rd      != b.rd);
    d[CTR_F_RS1]  = (a.rs1     != b.rs1);
    d[CTR_F_RS2]  = (a.rs2     != b.rs2);
    d[CTR_F_RS1V] = (a.reg_rs1 != b.reg_rs1);
    d[CTR_F_RS2V] = (a.reg_rs2 != b.reg_rs2);
    return d & mask;
  endfunction

endpackage

// File: rtl/ctr_obs_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module ctr_obs_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ctr_obs_checker.sv
// Queues retirement observations from two independently running core copies and
// compares them pairwise in retirement order under a runtime field mask.
module ctr_obs_checker
  import ctr_pkg::*;
#(
  parameter  int NREG  = 8,
  parameter  int XLEN  = CTR_XLEN,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int SKW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 retire_1_i,
  input  logic [XLEN-1:0]      instr_1_i,
  input  logic [NREG*XLEN-1:0] regfile_1_i,
  input  logic                 retire_2_i,
  input  logic [XLEN-1:0]      instr_2_i,
  input  logic [NREG*XLEN-1:0] regfile_2_i,
  input  logic [5:0]           ctr_mask_i,
  output logic                 ctr_equiv_o,
  output logic                 ctr_overflow_o,
  output logic [5:0]           ctr_diff_o,
  output logic [CNT_W-1:0]     ctr_cmp_cnt_o,
  output logic [SKW-1:0]       ctr_skew_o
);

  localparam int OBS_W = $bits(ctr_obs_t);

  function automatic ctr_obs_t build_obs(input logic [XLEN-1:0]      instr,
                                         input logic [NREG*XLEN-1:0] rf);
    ctr_obs_t o;
    o.op      = instr[31:24];
    o.rd      = instr[23:16];
    o.rs1     = instr[15:8];
    o.rs2     = instr[7:0];
    o.reg_rs1 = rf[(int'(instr[15:8]) % NREG) * XLEN +: XLEN];
    o.reg_rs2 = rf[(int'(instr[7:0]) % NREG) * XLEN +: XLEN];
    return o;
  endfunction

  ctr_obs_t       obs_1, obs_2, head_1, head_2;
  logic           full_1, full_2, empty_1, empty_2;
  logic [SKW-1:0] count_1, count_2, count_1_nx, count_2_nx;
  logic           pop, push_1_ok, push_2_ok, ovf_evt;
  logic [5:0]     diff;

  logic             equiv_q, equiv_d;
  logic             ovf_q, ovf_d;
  logic [5:0]       diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SKW-1:0]   skew_q, skew_d;

  assign obs_1 = build_obs(instr_1_i, regfile_1_i);
  assign obs_2 = build_obs(instr_2_i, regfile_2_i);

  ctr_obs_fifo #(.WIDTH(OBS_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (retire_1_i),
    .pop_i   (pop),
    .data_i  (obs_1),
    .head_o  (head_1),
    .full_o  (full_1),
    .empty_o (empty_1),
    .count_o (count_1)
  );

  ctr_obs_fifo #(.WIDTH(OBS_W), .DEPTH(DEPTH)) u_fifo_2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (retire_2_i),
    .pop_i   (pop),
    .data_i  (obs_2),
    .head_o  (head_2),
    .full_o  (full_2),
    .empty_o (empty_2),
    .count_o (count_2)
  );

  always_comb begin
    pop        = !empty_1 && !empty_2;
    diff       = pop ? obs_diff(head_1, head_2, ctr_mask_i) : '0;
    push_1_ok  = retire_1_i && (!full_1 || pop);
    push_2_ok  = retire_2_i && (!full_2 || pop);
    ovf_evt    = (retire_1_i && full_1 && !pop) || (retire_2_i && full_2 && !pop);
    count_1_nx = count_1 + {{(SKW-1){1'b0}}, push_1_ok} - {{(SKW-1){1'b0}}, pop};
    count_2_nx = count_2 + {{(SKW-1){1'b0}}, push_2_ok} - {{(SKW-1){1'b0}}, pop};

    equiv_d = equiv_q && !ovf_evt && (diff == '0);
    ovf_d   = ovf_q || ovf_evt;
    // A nonzero captured vector doubles as the "first mismatch seen" flag.
    diff_d  = diff_q;
    if ((diff != '0) && (diff_q == '0)) diff_d = diff;
    cnt_d   = cnt_q;
    if (pop && (cnt_q != '1)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    skew_d  = (count_2_nx != '0) ? count_2_nx : count_1_nx;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      equiv_q <= 1'b1;
      ovf_q   <= 1'b0;
      diff_q  <= '0;
      cnt_q   <= '0;
      skew_q  <= '0;
    end else begin
      equiv_q <= equiv_d;
      ovf_q   <= ovf_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      skew_q  <= skew_d;
    end
  end

  assign ctr_equiv_o    = equiv_q;
  assign ctr_overflow_o = ovf_q;
  assign ctr_diff_o     = diff_q;
  assign ctr_cmp_cnt_o  = cnt_q;
  assign ctr_skew_o     = skew_q;

  // After popping, one side is empty, so this edge's pushes leave at most one entry on it.
  a_one_side_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((count_1 > SKW'(1)) && (count_2 > SKW'(1))));

endmodule
